pb_l2_init_ctrl: RTL and testbench
==================================

# pb_l2_init_ctrl

Sequencing controller in front of a picobello mem tile's L2 SPM macro port. After reset, and again on a software request, it zero-fills the whole SPM one word per granted write. While filling, it holds off NoC-side traffic. Between fills it passes NoC requests through to the SRAM and tracks outstanding reads, so a re-fill never starts while responses are in flight.

## Interface
Parameters:
- `MemTileSize`, default 1048576: SPM size in bytes. Must equal the mem tile SAM region size.
- `DataWidth`, default 512: SRAM word width in bits.
- `InitValue`, default '0: word written during fill.
- `MaxOutstanding`, default 4: maximum in-flight reads, ≥1.
- Derived: `NumWords = MemTileSize/(DataWidth/8)`, power of two, ≥2. `IdxW = $clog2(NumWords)`. `CntW = $clog2(MaxOutstanding+1)`.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `init_req_i` in 1: request re-fill. Sampled as a level.
- `busy_o` out 1: high in INIT or DRAIN.
- `init_done_o` out 1: level. High once a fill has completed and no new fill has started.
- `done_pulse_o` out 1: one-cycle pulse at fill completion.
- `in_req_i` / `in_gnt_o` in/out 1: NoC-side request handshake.
- `in_we_i` in 1, `in_addr_i` in IdxW, `in_wdata_i` in DataWidth, `in_be_i` in DataWidth/8: request payload.
- `in_rvalid_o` out 1, `in_rdata_o` out DataWidth: read response.
- `mem_req_o` / `mem_gnt_i` out/in 1: SRAM request handshake.
- `mem_we_o` out 1, `mem_addr_o` out IdxW (word index), `mem_wdata_o` out DataWidth, `mem_be_o` out DataWidth/8: SRAM request payload.
- `mem_rvalid_i` in 1, `mem_rdata_i` in DataWidth: SRAM read response.

## Operation
- FSM states: INIT, IDLE, DRAIN. Reset state is INIT with `idx=0`, `outstanding=0`, `init_done_o=0`.
- **INIT**
  - Drives `mem_req_o=1`, `mem_we_o=1`, `mem_addr_o=idx`, `mem_wdata_o=InitValue`, `mem_be_o='1`.
  - Drives `in_gnt_o=0`.
  - `idx` increments on each `mem_gnt_i`.
  - When `mem_gnt_i` arrives with `idx==NumWords-1`: go to IDLE, set `init_done_o=1`, pulse `done_pulse_o` in the following cycle, wrap `idx` to 0.
  - `init_req_i` is ignored in INIT.
- **IDLE** (combinational pass-through)
  - `mem_req_o = in_req_i && !stall`, `in_gnt_o = mem_gnt_i && !stall`.
  - Payload is forwarded unchanged.
  - `stall = !in_we_i && outstanding==MaxOutstanding`. Writes are never stalled.
  - `in_rvalid_o`/`in_rdata_o` mirror `mem_rvalid_i`/`mem_rdata_i` in every state.
- **Outstanding counter**
  - +1 on a granted read (`mem_req_o && mem_gnt_i && !mem_we_o` in IDLE).
  - −1 on `mem_rvalid_i`.
  - Simultaneous +1 and −1 leaves it unchanged.
  - It never goes below 0: an `mem_rvalid_i` at 0 is dropped.
- **IDLE → DRAIN** when `init_req_i=1`.
  - A grant in that same cycle still completes.
  - `init_done_o` clears on entry to DRAIN.
- **DRAIN**
  - Drives `mem_req_o=0`, `in_gnt_o=0`.
  - When `outstanding==0` (registered value): go to INIT with `idx=0`.
  - Responses keep flowing to `in_rvalid_o` throughout.
- **Reset asserted mid-operation**: everything returns to reset state immediately; the fill restarts from word 0 after reset deasserts.

## Timing
- Reset values:
  - `busy_o=1` (INIT), `init_done_o=0`, `done_pulse_o=0`.
  - `in_gnt_o=0`, `in_rvalid_o=mem_rvalid_i`.
  - `mem_req_o=1`, `mem_we_o=1`, `mem_addr_o=0`.
- Fill duration is NumWords cycles when `mem_gnt_i` is held high. Each gnt-low cycle adds one cycle.
- First IDLE cycle (`busy_o=0`) is the cycle after the last fill grant. `done_pulse_o` and `init_done_o` are also high in that cycle.
- IDLE pass-through adds zero latency: request and grant are combinational, responses are combinational.
- DRAIN with `outstanding==0` lasts exactly 1 cycle, then INIT.
- FSM, `idx`, counter and flags are registered. Outputs are derived from the registered state plus IDLE pass-through only.

## Test plan
- **Reset fill.** MemTileSize=256, DataWidth=64 (32 words), `mem_gnt_i=1`, deassert `rst_i` → 32 consecutive writes of addresses 0..31, data 0, be=0xFF. Then `done_pulse_o` for one cycle and `init_done_o=1` in cycle 33.
- **Backpressure during fill.** Toggle `mem_gnt_i` 1,0,1,0 → each address is held until granted, no skip or duplicate. Fill completes after 64 cycles. `in_req_i=1` sees `in_gnt_o=0` throughout.
- **Outstanding limit.** MaxOutstanding=4, 5 back-to-back reads with no `rvalid` → 4 granted, the 5th stalls. One `mem_rvalid_i` lets it through the next cycle. A write while at limit is granted immediately.
- **Re-init with reads in flight.** 3 reads outstanding, pulse `init_req_i` → DRAIN. `in_gnt_o=0`. All 3 responses are delivered. INIT starts the cycle after the counter reaches 0. `init_done_o` is low from DRAIN entry until the new fill completes.
- **Simultaneous events.** A granted read and `mem_rvalid_i` in the same cycle leave the counter unchanged. A spurious `mem_rvalid_i` at count 0 keeps the counter at 0.
- **Reset mid-fill.** Assert `rst_i` at `idx=17` → `mem_addr_o=0` immediately. The fill restarts at 0 and completes all 32 words.

Source files
------------

// File: rtl/pb_l2_init_ctrl.sv
// pb_l2_init_ctrl: zero-fills the L2 SPM after reset or on request,
// and passes NoC traffic through while limiting in-flight reads.
module pb_l2_init_ctrl #(
    parameter int unsigned MemTileSize    = 1048576,
    parameter int unsigned DataWidth      = 512,
    parameter logic [DataWidth-1:0] InitValue = '0,
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned NumWords = MemTileSize / (DataWidth / 8),
    localparam int unsigned IdxW     = $clog2(NumWords),
    localparam int unsigned CntW     = $clog2(MaxOutstanding + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   init_req_i,
    output logic                   busy_o,
    output logic                   init_done_o,
    output logic                   done_pulse_o,
    input  logic                   in_req_i,
    output logic                   in_gnt_o,
    input  logic                   in_we_i,
    input  logic [IdxW-1:0]        in_addr_i,
    input  logic [DataWidth-1:0]   in_wdata_i,
    input  logic [DataWidth/8-1:0] in_be_i,
    output logic                   in_rvalid_o,
    output logic [DataWidth-1:0]   in_rdata_o,
    output logic                   mem_req_o,
    input  logic                   mem_gnt_i,
    output logic                   mem_we_o,
    output logic [IdxW-1:0]        mem_addr_o,
    output logic [DataWidth-1:0]   mem_wdata_o,
    output logic [DataWidth/8-1:0] mem_be_o,
    input  logic                   mem_rvalid_i,
    input  logic [DataWidth-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {
        StInit  = 2'd0,
        StIdle  = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);
    localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              pulse_q, pulse_d;
    logic              stall;
    logic              rd_gnt;
    logic              rsp_dec;

    assign busy_o       = (state_q != StIdle);
    assign init_done_o  = done_q;
    assign done_pulse_o = pulse_q;
    assign in_rvalid_o  = mem_rvalid_i;
    assign in_rdata_o   = mem_rdata_i;
    assign stall        = !in_we_i && (cnt_q == MaxCnt);

    // Next state, fill sequencing and SRAM port muxing.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        done_d      = done_q;
        pulse_d     = 1'b0;
        rd_gnt      = 1'b0;
        mem_req_o   = 1'b0;
        in_gnt_o    = 1'b0;
        mem_we_o    = in_we_i;
        mem_addr_o  = in_addr_i;
        mem_wdata_o = in_wdata_i;
        mem_be_o    = in_be_i;
        unique case (state_q)
            StInit: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = idx_q;
                mem_wdata_o = InitValue;
                mem_be_o    = '1;
                if (mem_gnt_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        done_d  = 1'b1;
                        pulse_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StIdle: begin
                mem_req_o = in_req_i && !stall;
                in_gnt_o  = mem_gnt_i && !stall;
                rd_gnt    = mem_req_o && mem_gnt_i && !in_we_i;
                if (init_req_i) begin
                    state_d = StDrain;
                    done_d  = 1'b0;
                end
            end
            StDrain: begin
                if (cnt_q == '0) begin
                    state_d = StInit;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = StInit;
                idx_d   = '0;
            end
        endcase
    end

    // In-flight read counter; a response with nothing pending is dropped.
    always_comb begin
        cnt_d   = cnt_q;
        rsp_dec = mem_rvalid_i && (cnt_q != '0);
        if (rd_gnt && !rsp_dec) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!rd_gnt && rsp_dec) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // State, index, counter and completion flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StInit;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: tb/tb_pb_l2_init_ctrl.sv
// Testbench for pb_l2_init_ctrl: directed tables, multi-cycle
// sequences and random traffic against a behavioural model.
module tb_pb_l2_init_ctrl;

    localparam int MemTileSize = 256;
    localparam int DataWidth   = 64;
    localparam int MaxOut      = 4;
    localparam int NumWords    = 32;
    localparam int IdxW        = 5;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 init_req;
    logic                 busy, init_done, done_pulse;
    logic                 in_req, in_gnt, in_we;
    logic [IdxW-1:0]      in_addr;
    logic [DataWidth-1:0] in_wdata;
    logic [7:0]           in_be;
    logic                 in_rvalid;
    logic [DataWidth-1:0] in_rdata;
    logic                 mem_req, mem_gnt, mem_we;
    logic [IdxW-1:0]      mem_addr;
    logic [DataWidth-1:0] mem_wdata;
    logic [7:0]           mem_be;
    logic                 mem_rvalid;
    logic [DataWidth-1:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    bit m_fill, m_drain, m_done, m_pulse;
    int m_word, m_inflight;

    typedef struct {
        logic req, we, gnt, rv;
        logic e_gnt, e_req;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    pb_l2_init_ctrl #(
        .MemTileSize    (MemTileSize),
        .DataWidth      (DataWidth),
        .InitValue      ('0),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .init_req_i   (init_req),
        .busy_o       (busy),
        .init_done_o  (init_done),
        .done_pulse_o (done_pulse),
        .in_req_i     (in_req),
        .in_gnt_o     (in_gnt),
        .in_we_i      (in_we),
        .in_addr_i    (in_addr),
        .in_wdata_i   (in_wdata),
        .in_be_i      (in_be),
        .in_rvalid_o  (in_rvalid),
        .in_rdata_o   (in_rdata),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_we_o     (mem_we),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_be_o     (mem_be),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fill     = 1'b1;
        m_drain    = 1'b0;
        m_done     = 1'b0;
        m_pulse    = 1'b0;
        m_word     = 0;
        m_inflight = 0;
    endtask

    task automatic check_model();
        bit stall;
        stall = !in_we && (m_inflight == MaxOut);
        chk("m_busy", busy, m_fill || m_drain);
        chk("m_init_done", init_done, m_done);
        chk("m_done_pulse", done_pulse, m_pulse);
        chk("m_rvalid", in_rvalid, mem_rvalid);
        chk("m_rdata", in_rdata, mem_rdata);
        if (m_fill) begin
            chk("m_fill_req", mem_req, 1);
            chk("m_fill_we", mem_we, 1);
            chk("m_fill_addr", mem_addr, m_word);
            chk("m_fill_wdata", mem_wdata, 0);
            chk("m_fill_be", mem_be, 8'hFF);
            chk("m_fill_ingnt", in_gnt, 0);
        end else if (m_drain) begin
            chk("m_drain_req", mem_req, 0);
            chk("m_drain_ingnt", in_gnt, 0);
        end else begin
            chk("m_idle_req", mem_req, in_req && !stall);
            chk("m_idle_ingnt", in_gnt, mem_gnt && !stall);
            chk("m_idle_we", mem_we, in_we);
            chk("m_idle_addr", mem_addr, in_addr);
            chk("m_idle_wdata", mem_wdata, in_wdata);
            chk("m_idle_be", mem_be, in_be);
        end
    endtask

    task automatic model_step();
        bit stall, rd, dec;
        if (rst) begin
            model_reset();
        end else begin
            stall = !in_we && (m_inflight == MaxOut);
            dec = mem_rvalid && (m_inflight > 0);
            rd = !m_fill && !m_drain && in_req && mem_gnt
                 && !stall && !in_we;
            m_pulse = 1'b0;
            if (m_fill) begin
                if (mem_gnt) begin
                    if (m_word == NumWords - 1) begin
                        m_fill  = 1'b0;
                        m_done  = 1'b1;
                        m_pulse = 1'b1;
                        m_word  = 0;
                    end else begin
                        m_word++;
                    end
                end
            end else if (m_drain) begin
                if (m_inflight == 0) begin
                    m_drain = 1'b0;
                    m_fill  = 1'b1;
                    m_word  = 0;
                end
            end else if (init_req) begin
                m_drain = 1'b1;
                m_done  = 1'b0;
            end
            m_inflight = m_inflight + int'(rd) - int'(dec);
        end
    endtask

    // Inputs are set just after a falling edge; this checks, advances
    // the model across the rising edge and returns at the next fall.
    task automatic cycle();
        #1;
        check_model();
        model_step();
        @(negedge clk);
    endtask

    task automatic run_fill(input bit toggle, output int n);
        n = 0;
        while (busy && n < 300) begin
            mem_gnt = toggle ? n[0] : 1'b1;
            cycle();
            n++;
        end
        if (busy) chk("fill_timeout", busy, 0);
        mem_gnt = 1'b1;
    endtask

    task automatic push(input int cnt, input logic req, input logic we,
                        input logic gnt, input logic rv,
                        input logic eg, input logic er);
        vec_t v;
        v = '{req: req, we: we, gnt: gnt, rv: rv, e_gnt: eg, e_req: er};
        for (int i = 0; i < cnt; i++) tbl.push_back(v);
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        init_req   = 1'b0;
        in_req     = 1'b0;
        in_we      = 1'b0;
        in_addr    = '0;
        in_wdata   = '0;
        in_be      = '0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hDEAD_BEEF_0123_4567;
        in_req     = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_init_done", init_done, 0);
        chk("rst_pulse", done_pulse, 0);
        chk("rst_in_gnt", in_gnt, 0);
        chk("rst_rvalid", in_rvalid, 1);
        chk("rst_mem_req", mem_req, 1);
        chk("rst_mem_we", mem_we, 1);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        in_req     = 1'b0;
        rst        = 1'b0;
        model_reset();

        run_fill(1'b0, n);
        chk("fill_len_gnt1", n, NumWords);
        #1;
        chk("first_idle_pulse", done_pulse, 1);
        chk("first_idle_done", init_done, 1);
        cycle();
        #1;
        chk("pulse_one_cycle", done_pulse, 0);
        chk("done_level", init_done, 1);
        @(negedge clk);

        push(4, 1, 0, 1, 0, 1, 1);
        push(1, 1, 0, 1, 0, 0, 0);
        push(1, 1, 0, 1, 1, 0, 0);
        push(1, 1, 0, 1, 0, 1, 1);
        push(1, 1, 1, 1, 0, 1, 1);
        push(1, 1, 0, 1, 0, 0, 0);
        push(4, 0, 0, 0, 1, 0, 0);
        push(1, 1, 0, 1, 0, 1, 1);
        push(1, 1, 0, 1, 1, 1, 1);
        push(3, 1, 0, 1, 0, 1, 1);
        push(1, 1, 0, 1, 0, 0, 0);
        push(4, 0, 0, 0, 1, 0, 0);
        push(1, 0, 0, 0, 1, 0, 0);
        push(4, 1, 0, 1, 0, 1, 1);
        push(1, 1, 0, 1, 0, 0, 0);
        push(4, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            in_req     = tbl[i].req;
            in_we      = tbl[i].we;
            mem_gnt    = tbl[i].gnt;
            mem_rvalid = tbl[i].rv;
            in_addr    = IdxW'($urandom);
            in_wdata   = {$urandom, $urandom};
            in_be      = 8'($urandom);
            mem_rdata  = {$urandom, $urandom};
            #1;
            chk($sformatf("tbl%0d_in_gnt", i), in_gnt, tbl[i].e_gnt);
            chk($sformatf("tbl%0d_mem_req", i), mem_req, tbl[i].e_req);
            cycle();
        end
        in_req     = 1'b0;
        in_we      = 1'b0;
        mem_rvalid = 1'b0;

        init_req = 1'b1;
        cycle();
        init_req = 1'b0;
        #1;
        chk("drain_entry_done", init_done, 0);
        chk("drain_entry_req", mem_req, 0);
        cycle();
        #1;
        chk("drain_1cyc_req", mem_req, 1);
        chk("drain_1cyc_addr", mem_addr, 0);
        in_req = 1'b1;
        run_fill(1'b1, n);
        chk("fill_len_toggle", n, 2 * NumWords);
        in_req = 1'b0;

        in_req  = 1'b1;
        in_we   = 1'b0;
        mem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        in_req   = 1'b0;
        init_req = 1'b1;
        cycle();
        init_req = 1'b0;
        in_req   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_rvalid = (i == 1) || (i == 2) || (i == 4);
            mem_rdata  = {$urandom, $urandom};
            #1;
            chk("drain_busy", busy, 1);
            chk("drain_in_gnt", in_gnt, 0);
            chk("drain_rvalid", in_rvalid, mem_rvalid);
            chk("drain_done_low", init_done, 0);
            cycle();
        end
        mem_rvalid = 1'b0;
        #1;
        chk("drain_last_req", mem_req, 0);
        cycle();
        #1;
        chk("refill_start_req", mem_req, 1);
        chk("refill_start_we", mem_we, 1);
        chk("refill_done_low", init_done, 0);
        run_fill(1'b0, n);
        chk("fill_len_refill", n, NumWords);
        in_req = 1'b0;

        init_req = 1'b1;
        cycle();
        init_req = 1'b0;
        cycle();
        n = 0;
        while (m_word < 17 && n < 100) begin
            cycle();
            n++;
        end
        #1;
        chk("midfill_addr17", mem_addr, 17);
        rst = 1'b1;
        #1;
        chk("midfill_rst_addr", mem_addr, 0);
        chk("midfill_rst_busy", busy, 1);
        model_reset();
        cycle();
        rst = 1'b0;
        run_fill(1'b0, n);
        chk("fill_len_after_rst", n, NumWords);

        for (int i = 0; i < 3000; i++) begin
            init_req   = ($urandom % 64) == 0;
            in_req     = $urandom % 2;
            in_we      = ($urandom % 10) < 3;
            mem_gnt    = ($urandom % 10) < 7;
            mem_rvalid = $urandom % 2;
            in_addr    = IdxW'($urandom);
            in_wdata   = {$urandom, $urandom};
            in_be      = 8'($urandom);
            mem_rdata  = {$urandom, $urandom};
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
